fp_div_seq: RTL and testbench

FP_DIV_SEQ -- requirements
Module: fp_div_seq

---
 rtl/fp_div_seq.sv | 216 +++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// Sequential binary32 divider: restoring radix-2, fixed 29-cycle start-to-done latency.
// Define FP_DIV_SUBNORM_EN for subnormal operand/result support; otherwise subnormals flush to zero.
module fp_div_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] fp_X,
   input  logic [31:0] fp_Y,
   input  logic [2:0]  r_mode,
   output logic        busy,
   output logic        done,
   output logic [31:0] fp_Z,
   output logic        ovrf,
   output logic        udrf,
   output logic        dz
);
   typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_t;

   state_t             state_q, state_d;
   logic [31:0]        x_q, x_d, y_q, y_d, spec_z_q, spec_z_d, z_q, z_d;
   logic [2:0]         rm_q, rm_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [25:0]        rem_q, rem_d, quo_q, quo_d;
   logic [23:0]        div_q, div_d;
   logic signed [9:0]  exp_q, exp_d;
   logic               sign_q, sign_d, spec_q, spec_d, spec_dz_q, spec_dz_d;
   logic               ovrf_q, ovrf_d, udrf_q, udrf_d, dz_q, dz_d;

   // Returns {biased exponent (10b, may be <1 for normalized subnormals), 24b significand}
   function automatic logic [33:0] norm_op(input logic [31:0] f);
      logic [23:0] m;
      logic [9:0]  e;
`ifdef FP_DIV_SUBNORM_EN
      logic [4:0]  lz;
      m  = {(f[30:23] != 8'd0), f[22:0]};
      lz = 5'd0;
      for (int i = 0; i < 24; i++) if (m[i]) lz = 5'(23 - i);
      m  = m << lz;
      e  = (f[30:23] == 8'd0) ? (10'd1 - {5'd0, lz}) : {2'b00, f[30:23]};
`else
      m  = {1'b1, f[22:0]};
      e  = {2'b00, f[30:23]};
`endif
      return {e, m};
   endfunction

   logic [33:0] nx, ny;
   logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, mx_lt, res_sign;
   assign nx       = norm_op(x_q);
   assign ny       = norm_op(y_q);
   assign x_nan    = (x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'd0);
   assign y_nan    = (y_q[30:23] == 8'hFF) && (y_q[22:0] != 23'd0);
   assign x_inf    = (x_q[30:23] == 8'hFF) && (x_q[22:0] == 23'd0);
   assign y_inf    = (y_q[30:23] == 8'hFF) && (y_q[22:0] == 23'd0);
`ifdef FP_DIV_SUBNORM_EN
   assign x_zero   = (x_q[30:0] == 31'd0);
   assign y_zero   = (y_q[30:0] == 31'd0);
`else
   assign x_zero   = (x_q[30:23] == 8'd0);
   assign y_zero   = (y_q[30:23] == 8'd0);
`endif
   assign mx_lt    = nx[23:0] < ny[23:0];
   assign res_sign = x_q[31] ^ y_q[31];

   // Rounding of the 26-bit quotient (1.f23 g r) plus remainder sticky
   logic        tiny, g_bit, r_bit, st_bit, inexact, inc, ovf;
   logic [25:0] qs;
   logic [9:0]  e_adj;
   logic [32:0] sum;
   logic [31:0] res_z;
   logic        res_udrf, res_ovrf;
`ifdef FP_DIV_SUBNORM_EN
   logic signed [9:0] sh_amt;
   logic [4:0]        sh;
   logic [51:0]       wide;
`endif

   always_comb begin
      tiny     = exp_q < 10'sd1;
`ifdef FP_DIV_SUBNORM_EN
      sh_amt   = 10'sd1 - exp_q;
      sh       = !tiny ? 5'd0 : (sh_amt > 10'sd27) ? 5'd27 : sh_amt[4:0];
      wide     = {quo_q, 26'd0} >> sh;
      qs       = wide[51:26];
      st_bit   = (rem_q != 26'd0) || (wide[25:0] != 26'd0);
      e_adj    = tiny ? 10'd0 : 10'(exp_q - 10'sd1);
`else
      qs       = quo_q;
      st_bit   = (rem_q != 26'd0);
      e_adj    = 10'(exp_q - 10'sd1);
`endif
      g_bit    = qs[1];
      r_bit    = qs[0];
      inexact  = g_bit | r_bit | st_bit;
      case (rm_q)
         3'b001:  inc = 1'b0;
         3'b010:  inc = sign_q & inexact;
         3'b011:  inc = ~sign_q & inexact;
         3'b100:  inc = g_bit;
         default: inc = g_bit & (r_bit | st_bit | qs[2]);
      endcase
      // Hidden bit lands in the exponent field, so a rounding carry bumps it for free
      sum      = {e_adj, 23'd0} + {9'd0, qs[25:2]} + {32'd0, inc};
      ovf      = $signed(sum[32:23]) > 10'sd254;
      res_z    = {sign_q, sum[30:0]};
      res_ovrf = 1'b0;
      res_udrf = tiny & inexact;
      if (spec_q) begin
         res_z    = spec_z_q;
         res_udrf = 1'b0;
`ifndef FP_DIV_SUBNORM_EN
      end else if (tiny) begin
         res_z    = {sign_q, 31'd0};
         res_udrf = 1'b1;
`endif
      end else if (ovf) begin
         res_ovrf = 1'b1;
         res_udrf = 1'b0;
         case (rm_q)
            3'b001:  res_z = {sign_q, 8'hFE, 23'h7FFFFF};
            3'b010:  res_z = sign_q ? {1'b1, 8'hFF, 23'd0} : {1'b0, 8'hFE, 23'h7FFFFF};
            3'b011:  res_z = sign_q ? {1'b1, 8'hFE, 23'h7FFFFF} : {1'b0, 8'hFF, 23'd0};
            default: res_z = {sign_q, 8'hFF, 23'd0};
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = UNPACK;
         UNPACK:  state_d = DIVIDE;
         DIVIDE:  if (cnt_q == 5'd26) state_d = ROUND;
         ROUND:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      x_d = x_q;  y_d = y_q;  rm_d = rm_q;  cnt_d = cnt_q;
      rem_d = rem_q;  quo_d = quo_q;  div_d = div_q;  exp_d = exp_q;
      sign_d = sign_q;  spec_d = spec_q;  spec_z_d = spec_z_q;  spec_dz_d = spec_dz_q;
      z_d = z_q;  ovrf_d = ovrf_q;  udrf_d = udrf_q;  dz_d = dz_q;
      case (state_q)
         IDLE: if (start) begin
            x_d  = fp_X;
            y_d  = fp_Y;
            rm_d = r_mode;
         end
         UNPACK: begin
            cnt_d     = 5'd0;
            quo_d     = 26'd0;
            div_d     = ny[23:0];
            rem_d     = mx_lt ? {1'b0, nx[23:0], 1'b0} : {2'b00, nx[23:0]};
            exp_d     = nx[33:24] - ny[33:24] + 10'd127 - {9'd0, mx_lt};
            sign_d    = res_sign;
            spec_d    = 1'b1;
            spec_dz_d = 1'b0;
            if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf))
               spec_z_d = 32'h7FC00000;
            else if (x_inf)
               spec_z_d = {res_sign, 8'hFF, 23'd0};
            else if (y_inf || x_zero)
               spec_z_d = {res_sign, 31'd0};
            else if (y_zero) begin
               spec_z_d  = {res_sign, 8'hFF, 23'd0};
               spec_dz_d = 1'b1;
            end else begin
               spec_z_d  = 32'd0;
               spec_d    = 1'b0;
            end
         end
         DIVIDE: if (cnt_q != 5'd26) begin
            cnt_d = cnt_q + 5'd1;
            if (rem_q >= {2'b00, div_q}) begin
               quo_d = {quo_q[24:0], 1'b1};
               rem_d = (rem_q - {2'b00, div_q}) << 1;
            end else begin
               quo_d = {quo_q[24:0], 1'b0};
               rem_d = rem_q << 1;
            end
         end
         ROUND: begin
            z_d    = res_z;
            ovrf_d = res_ovrf;
            udrf_d = res_udrf;
            dz_d   = spec_q & spec_dz_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q <= '0;  y_q <= '0;  rm_q <= '0;  cnt_q <= '0;
         rem_q <= '0;  quo_q <= '0;  div_q <= '0;  exp_q <= '0;
         sign_q <= 1'b0;  spec_q <= 1'b0;  spec_z_q <= '0;  spec_dz_q <= 1'b0;
         z_q <= '0;  ovrf_q <= 1'b0;  udrf_q <= 1'b0;  dz_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q <= x_d;  y_q <= y_d;  rm_q <= rm_d;  cnt_q <= cnt_d;
         rem_q <= rem_d;  quo_q <= quo_d;  div_q <= div_d;  exp_q <= exp_d;
         sign_q <= sign_d;  spec_q <= spec_d;  spec_z_q <= spec_z_d;  spec_dz_q <= spec_dz_d;
         z_q <= z_d;  ovrf_q <= ovrf_d;  udrf_q <= udrf_d;  dz_q <= dz_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign fp_Z = z_q;
   assign ovrf = ovrf_q;
   assign udrf = udrf_q;
   assign dz   = dz_q;
endmodule

// File: tb/tb_fp_div_seq.sv
// Directed-vector bench for fp_div_seq: results, flags, latency, reset abort and busy-start rejection.
module tb_fp_div_seq;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [31:0] fp_X, fp_Y, fp_Z;
   logic [2:0]  r_mode;
   logic        busy, done, ovrf, udrf, dz;
   int          n_cmp = 0;
   int          n_err = 0;

   fp_div_seq dut (
      .clk(clk), .rst(rst), .start(start), .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode),
      .busy(busy), .done(done), .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf), .dz(dz)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   // pulse_at > 0 re-asserts start (other operands) on edge N+pulse_at while busy
   task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] m, input logic [31:0] ez,
                        input logic eo, input logic eu, input logic ed, input int pulse_at);
      int lat;
      int extra;
      @(negedge clk);
      fp_X = x;  fp_Y = y;  r_mode = m;  start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;  fp_X = 32'h3F800000;  fp_Y = 32'h40400000;  r_mode = 3'b011;
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         start = (pulse_at > 0) && (lat == pulse_at - 1);
      end
      start = 1'b0;
      check({tag, "_lat"}, 32'(lat), 32'd29);
      check({tag, "_z"},   fp_Z, ez);
      check({tag, "_flags"}, {29'd0, ovrf, udrf, dz}, {29'd0, eo, eu, ed});
      @(posedge clk); #1;
      check({tag, "_end"}, {30'd0, busy, done}, 32'd0);
      if (pulse_at > 0) begin
         extra = 0;
         repeat (35) begin
            @(posedge clk); #1;
            if (done) extra++;
         end
         check({tag, "_nodup"}, 32'(extra), 32'd0);
         check({tag, "_hold"}, fp_Z, ez);
      end
   endtask

   initial begin
      int cnt;
      rst = 1'b1;  start = 1'b0;  fp_X = '0;  fp_Y = '0;  r_mode = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", {26'd0, busy, done, ovrf, udrf, dz, 1'b0}, 32'd0);
      check("rst_z", fp_Z, 32'd0);
      rst = 1'b0;

      do_op("six_by_two", 32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 0, 0, 0, 0);
      do_op("third_rne",  32'h3F800000, 32'h40400000, 3'b000, 32'h3EAAAAAB, 0, 0, 0, 0);
      do_op("third_rtz",  32'h3F800000, 32'h40400000, 3'b001, 32'h3EAAAAAA, 0, 0, 0, 0);
      do_op("third_rup",  32'h3F800000, 32'h40400000, 3'b011, 32'h3EAAAAAB, 0, 0, 0, 0);
      do_op("third_rdn",  32'h3F800000, 32'h40400000, 3'b010, 32'h3EAAAAAA, 0, 0, 0, 0);
      do_op("third_rmm",  32'h3F800000, 32'h40400000, 3'b100, 32'h3EAAAAAB, 0, 0, 0, 0);
      do_op("third_m7",   32'h3F800000, 32'h40400000, 3'b111, 32'h3EAAAAAB, 0, 0, 0, 0);
      do_op("nthird_rdn", 32'hBF800000, 32'h40400000, 3'b010, 32'hBEAAAAAB, 0, 0, 0, 0);
      do_op("nthird_rup", 32'hBF800000, 32'h40400000, 3'b011, 32'hBEAAAAAA, 0, 0, 0, 0);
      do_op("neg_three",  32'hBFC00000, 32'h3F000000, 3'b000, 32'hC0400000, 0, 0, 0, 0);
      do_op("one_by_one", 32'h3F800000, 32'h3F800000, 3'b000, 32'h3F800000, 0, 0, 0, 0);
      do_op("div_zero",   32'h3F800000, 32'h00000000, 3'b000, 32'h7F800000, 0, 0, 1, 0);
      do_op("ndiv_zero",  32'hBF800000, 32'h00000000, 3'b000, 32'hFF800000, 0, 0, 1, 0);
      do_op("zero_zero",  32'h00000000, 32'h00000000, 3'b000, 32'h7FC00000, 0, 0, 0, 0);
      do_op("nan_in",     32'h7F800001, 32'h3F800000, 3'b000, 32'h7FC00000, 0, 0, 0, 0);
      do_op("inf_inf",    32'h7F800000, 32'hFF800000, 3'b000, 32'h7FC00000, 0, 0, 0, 0);
      do_op("inf_fin",    32'h7F800000, 32'h40000000, 3'b000, 32'h7F800000, 0, 0, 0, 0);
      do_op("fin_ninf",   32'h40000000, 32'hFF800000, 3'b000, 32'h80000000, 0, 0, 0, 0);
      do_op("nzero_fin",  32'h80000000, 32'h40400000, 3'b000, 32'h80000000, 0, 0, 0, 0);
      do_op("ovf_rne",    32'h7F7FFFFF, 32'h3F000000, 3'b000, 32'h7F800000, 1, 0, 0, 0);
      do_op("ovf_rtz",    32'h7F7FFFFF, 32'h3F000000, 3'b001, 32'h7F7FFFFF, 1, 0, 0, 0);
      do_op("novf_rdn",   32'hFF7FFFFF, 32'h3F000000, 3'b010, 32'hFF800000, 1, 0, 0, 0);
      do_op("novf_rup",   32'hFF7FFFFF, 32'h3F000000, 3'b011, 32'hFF7FFFFF, 1, 0, 0, 0);
`ifdef FP_DIV_SUBNORM_EN
      do_op("tiny_res",   32'h00800000, 32'h40000000, 3'b000, 32'h00400000, 0, 0, 0, 0);
      do_op("sub_opnd",   32'h00400000, 32'h3F800000, 3'b000, 32'h00400000, 0, 0, 0, 0);
`else
      do_op("tiny_res",   32'h00800000, 32'h40000000, 3'b000, 32'h00000000, 0, 1, 0, 0);
      do_op("sub_opnd",   32'h00400000, 32'h3F800000, 3'b000, 32'h00000000, 0, 0, 0, 0);
`endif
      do_op("busy_start", 32'h40C00000, 32'h40000000, 3'b000, 32'h40400000, 0, 0, 0, 5);

      // Abort: rst sampled on edge N+10 of an operation
      @(negedge clk);
      fp_X = 32'h3F800000;  fp_Y = 32'h40400000;  r_mode = 3'b000;  start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_state", {30'd0, busy, done}, 32'd0);
      check("abort_z", fp_Z, 32'd0);
      cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) cnt++;
      end
      check("abort_nodone", 32'(cnt), 32'd0);

      // start on the same edge as rst is ignored
      @(negedge clk);
      rst = 1'b1;  start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;  start = 1'b0;
      @(posedge clk); #1;
      check("rst_start_ignored", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
      $fatal(1);
   end
endmodule
